mem_write_arb: RTL and testbench



---
 rtl/mem_write_arb.sv | 141 ++++++++++++++
 tb/tb_mem_write_arb.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_arb.sv
// rtl/mem_write_arb.sv - N-client burst-locked write arbiter with a one-entry registered output stage
// Define MEM_WRITE_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module mem_write_arb #(
    parameter int WORD_WIDTH        = 8,
    parameter int NUM_WORDS_IN_LINE = 32,
    parameter int ADDR_WIDTH        = 19,
    parameter int NUM_CLIENTS       = 4,
    localparam int ID_W             = $clog2(NUM_CLIENTS),
    localparam int LV_W             = $clog2(NUM_WORDS_IN_LINE),
    localparam int LINE_W           = NUM_WORDS_IN_LINE * WORD_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CLIENTS-1:0]        cl_mem_req,
    output logic [NUM_CLIENTS-1:0]        cl_mem_gnt,
    input  logic [NUM_CLIENTS-1:0]        cl_last,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cl_mem_start_addr,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cl_mem_size_bytes,
    input  logic [NUM_CLIENTS*LINE_W-1:0] cl_mem_data,
    input  logic [NUM_CLIENTS*LV_W-1:0]   cl_mem_last_valid,
    output logic                          mem_req,
    input  logic                          mem_gnt,
    output logic                          mem_last,
    output logic [ADDR_WIDTH-1:0]         mem_start_addr,
    output logic [ADDR_WIDTH-1:0]         mem_size_bytes,
    output logic [LINE_W-1:0]             mem_data,
    output logic [LV_W-1:0]               mem_last_valid,
    output logic [ID_W-1:0]               mem_client_id
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] owner_q, owner_d;
    logic [ID_W-1:0] win_id, sel_id, idx;
    logic            win_found, sel_valid, slot_free;

    assign slot_free = !mem_req || mem_gnt;

`ifdef MEM_WRITE_ARB_FIXED_PRIO_EN
    // Scan downwards so the lowest requesting index is the last one written.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = '0;
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            idx = ID_W'(k);
            if (cl_mem_req[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end
`else
    logic [ID_W-1:0] rr_q, rr_d, next_rr;

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            idx = ID_W'((int'(rr_q) + k) % NUM_CLIENTS);
            if (!win_found && cl_mem_req[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    assign next_rr = (sel_id == ID_W'(NUM_CLIENTS - 1)) ? '0 : sel_id + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) rr_q <= '0;
        else        rr_q <= rr_d;
    end
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cl_mem_gnt = '0;
        sel_valid  = 1'b0;
        sel_id     = win_id;
`ifndef MEM_WRITE_ARB_FIXED_PRIO_EN
        rr_d       = rr_q;
`endif
        if (state_q == IDLE) begin
            sel_valid = win_found && slot_free;
        end else begin
            sel_id    = owner_q;
            sel_valid = slot_free && cl_mem_req[owner_q];
        end
        if (!rst_n) sel_valid = 1'b0;
        if (sel_valid) begin
            cl_mem_gnt[sel_id] = 1'b1;
            if (cl_last[sel_id]) begin
                state_d = IDLE;
`ifndef MEM_WRITE_ARB_FIXED_PRIO_EN
                rr_d    = next_rr;
`endif
            end else begin
                state_d = LOCKED;
                owner_d = sel_id;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Output slot reloads whenever a beat is granted, which covers the drain-and-fill case.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_req        <= 1'b0;
            mem_last       <= 1'b0;
            mem_start_addr <= '0;
            mem_size_bytes <= '0;
            mem_data       <= '0;
            mem_last_valid <= '0;
            mem_client_id  <= '0;
        end else if (sel_valid) begin
            mem_req        <= 1'b1;
            mem_last       <= cl_last[sel_id];
            mem_start_addr <= cl_mem_start_addr[int'(sel_id) * ADDR_WIDTH +: ADDR_WIDTH];
            mem_size_bytes <= cl_mem_size_bytes[int'(sel_id) * ADDR_WIDTH +: ADDR_WIDTH];
            mem_data       <= cl_mem_data[int'(sel_id) * LINE_W +: LINE_W];
            mem_last_valid <= cl_mem_last_valid[int'(sel_id) * LV_W +: LV_W];
            mem_client_id  <= sel_id;
        end else if (mem_gnt) begin
            mem_req <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_write_arb.sv
// tb/tb_mem_write_arb.sv - scoreboard testbench for mem_write_arb
`timescale 1ns/1ps
module tb_mem_write_arb;

    localparam int NC  = 4;
    localparam int AW  = 19;
    localparam int LW  = 256;
    localparam int LVW = 5;

    typedef struct packed {
        logic [1:0]    id;
        logic          last;
        logic [AW-1:0] addr;
        logic [AW-1:0] size;
        logic [LVW-1:0] lv;
        logic [LW-1:0] data;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NC-1:0]     cl_mem_req, cl_mem_gnt, cl_last;
    logic [NC*AW-1:0]  cl_mem_start_addr, cl_mem_size_bytes;
    logic [NC*LW-1:0]  cl_mem_data;
    logic [NC*LVW-1:0] cl_mem_last_valid;
    logic              mem_req, mem_gnt, mem_last;
    logic [AW-1:0]     mem_start_addr, mem_size_bytes;
    logic [LW-1:0]     mem_data;
    logic [LVW-1:0]    mem_last_valid;
    logic [1:0]        mem_client_id;

    mem_write_arb dut (
        .clk(clk), .rst_n(rst_n),
        .cl_mem_req(cl_mem_req), .cl_mem_gnt(cl_mem_gnt), .cl_last(cl_last),
        .cl_mem_start_addr(cl_mem_start_addr), .cl_mem_size_bytes(cl_mem_size_bytes),
        .cl_mem_data(cl_mem_data), .cl_mem_last_valid(cl_mem_last_valid),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_last(mem_last),
        .mem_start_addr(mem_start_addr), .mem_size_bytes(mem_size_bytes),
        .mem_data(mem_data), .mem_last_valid(mem_last_valid), .mem_client_id(mem_client_id)
    );

    always #5 clk = ~clk;

    int    n_cmp = 0, n_err = 0, cyc = 0;
    int    left[NC], len[NC], bidx[NC], seq[NC];
    bit    hold[NC];
    logic  mg;
    beat_t sbq[$];
    int    out_ids[$], out_last[$], out_cyc[$];
    bit    lat_pend, prev_stall;
    beat_t lat_b, prev_b;

    function automatic beat_t make_beat(input int i);
        beat_t b;
        b.id   = 2'(i);
        b.last = (bidx[i] == len[i] - 1);
        b.addr = AW'(32'h100 + i * 32'h1000);
        b.size = AW'(len[i] * 32);
        b.lv   = LVW'(seq[i]);
        b.data = {8{8'(i), 8'(seq[i]), 16'(16'hC3A5 ^ (seq[i] * 7))}};
        return b;
    endfunction

    function automatic beat_t out_beat();
        beat_t b;
        b.id = mem_client_id; b.last = mem_last; b.addr = mem_start_addr;
        b.size = mem_size_bytes; b.lv = mem_last_valid; b.data = mem_data;
        return b;
    endfunction

    function automatic bit busy();
        bit r = (sbq.size() > 0) || (mem_req === 1'b1);
        for (int i = 0; i < NC; i++) if (left[i] > 0) r = 1'b1;
        return r;
    endfunction

    task automatic drive();
        beat_t b;
        for (int i = 0; i < NC; i++) begin
            b = make_beat(i);
            cl_mem_req[i] = (left[i] > 0) && !hold[i];
            cl_last[i] = b.last;
            cl_mem_start_addr[i*AW +: AW] = b.addr;
            cl_mem_size_bytes[i*AW +: AW] = b.size;
            cl_mem_last_valid[i*LVW +: LVW] = b.lv;
            cl_mem_data[i*LW +: LW] = b.data;
        end
        mem_gnt = mg;
    endtask

    // One clock: observe at negedge, advance client streams after the edge.
    task automatic step();
        beat_t ob, eb;
        logic [NC-1:0] g;
        bit xfer[NC];
        drive();
        @(negedge clk);
        ob = out_beat();
        g = cl_mem_gnt;
        if (lat_pend) begin
            n_cmp++;
            if (mem_req !== 1'b1 || ob !== lat_b) begin
                n_err++;
                $display("FAIL latency cyc=%0d got req=%b beat=%h want req=1 beat=%h", cyc, mem_req, ob, lat_b);
            end
        end
        if (prev_stall && rst_n) begin
            n_cmp++;
            if (ob !== prev_b) begin
                n_err++;
                $display("FAIL hold_stable cyc=%0d got %h want %h", cyc, ob, prev_b);
            end
        end
        n_cmp++;
        if ($countones(g) > 1 || (g & ~cl_mem_req) != '0) begin
            n_err++;
            $display("FAIL gnt_onehot cyc=%0d got gnt=%b req=%b want one-hot subset of req", cyc, g, cl_mem_req);
        end
        for (int i = 0; i < NC; i++) xfer[i] = 1'b0;
        lat_pend = 1'b0;
        if (!rst_n) begin
            n_cmp++;
            if (g !== '0) begin
                n_err++;
                $display("FAIL gnt_in_reset cyc=%0d got %b want 0000", cyc, g);
            end
            sbq.delete();
            prev_stall = 1'b0;
        end else begin
            if (mem_req === 1'b1 && !mem_gnt) begin
                n_cmp++;
                if (g !== '0) begin
                    n_err++;
                    $display("FAIL gnt_backpressure cyc=%0d got %b want 0000", cyc, g);
                end
            end
            if (mem_req === 1'b1 && mem_gnt) begin
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_beat cyc=%0d got %h want none", cyc, ob);
                end else begin
                    eb = sbq.pop_front();
                    if (ob !== eb) begin
                        n_err++;
                        $display("FAIL beat_data cyc=%0d got %h want %h", cyc, ob, eb);
                    end
                end
                out_ids.push_back(int'(mem_client_id));
                out_last.push_back(int'(mem_last));
                out_cyc.push_back(cyc);
            end
            for (int i = 0; i < NC; i++) begin
                if (g[i] && cl_mem_req[i]) begin
                    eb = make_beat(i);
                    sbq.push_back(eb);
                    lat_pend = 1'b1;
                    lat_b = eb;
                    xfer[i] = 1'b1;
                end
            end
            prev_stall = (mem_req === 1'b1) && !mem_gnt;
            prev_b = ob;
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NC; i++) begin
            if (xfer[i]) begin
                seq[i]++;
                if (bidx[i] == len[i] - 1) begin
                    bidx[i] = 0;
                    left[i]--;
                end else begin
                    bidx[i]++;
                end
            end
        end
    endtask

    task automatic run_until_done(input int maxc, input string name);
        int c = 0;
        while (busy() && c < maxc) begin
            step();
            c++;
        end
        n_cmp++;
        if (busy()) begin
            n_err++;
            $display("FAIL %s_timeout got busy after %0d cycles want idle", name, maxc);
        end
    endtask

    task automatic clear_log();
        out_ids.delete(); out_last.delete(); out_cyc.delete();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NC; i++) begin
            left[i] = 0; len[i] = 1; bidx[i] = 0; seq[i] = 0; hold[i] = 1'b0;
        end
        mg = 1'b1;
        left[0] = 1;
        rst_n = 1'b0;
        step();
        step();
        n_cmp++;
        if (mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mem_req got %b want 0", mem_req);
        end
        n_cmp++;
        if (out_beat() !== '0) begin
            n_err++;
            $display("FAIL reset_fields got %h want 0", out_beat());
        end
        rst_n = 1'b1;
        clear_log();
        run_until_done(20, "reset");
        n_cmp++;
        if (out_ids.size() != 1 || out_ids[0] != 0) begin
            n_err++;
            $display("FAIL reset_first_beat got %0d beats want 1 beat from client 0", out_ids.size());
        end
    endtask

    task automatic test_single_burst();
        int exp_last[$];
        exp_last = '{0, 0, 1};
        clear_log();
        len[0] = 3; left[0] = 1; bidx[0] = 0;
        run_until_done(30, "single");
        n_cmp++;
        if (out_ids.size() != 3) begin
            n_err++;
            $display("FAIL single_count got %0d want 3", out_ids.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (out_ids[k] != 0 || out_last[k] != exp_last[k]) begin
                    n_err++;
                    $display("FAIL single_beat%0d got id=%0d last=%0d want id=0 last=%0d", k, out_ids[k], out_last[k], exp_last[k]);
                end
            end
            n_cmp++;
            if (out_cyc[1] != out_cyc[0] + 1 || out_cyc[2] != out_cyc[1] + 1) begin
                n_err++;
                $display("FAIL single_consecutive got cycles %0d,%0d,%0d want consecutive", out_cyc[0], out_cyc[1], out_cyc[2]);
            end
        end
    endtask

    task automatic test_round_robin();
        int exp[$];
`ifdef MEM_WRITE_ARB_FIXED_PRIO_EN
        exp = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
`else
        exp = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
`endif
        apply_reset();
        clear_log();
        for (int i = 0; i < NC; i++) begin
            len[i] = 1; left[i] = 3; bidx[i] = 0;
        end
        run_until_done(60, "rr");
        n_cmp++;
        if (out_ids.size() != exp.size()) begin
            n_err++;
            $display("FAIL rr_count got %0d want %0d", out_ids.size(), exp.size());
        end else begin
            for (int k = 0; k < exp.size(); k++) begin
                n_cmp++;
                if (out_ids[k] != exp[k]) begin
                    n_err++;
                    $display("FAIL rr_order[%0d] got %0d want %0d", k, out_ids[k], exp[k]);
                end
            end
        end
    endtask

    task automatic test_burst_lock();
        int exp[$];
        int c = 0;
        exp = '{1, 1, 1, 1, 2};
        clear_log();
        len[1] = 4; left[1] = 1; bidx[1] = 0;
        while (bidx[1] < 2 && c < 20) begin step(); c++; end
        len[2] = 1; left[2] = 1; bidx[2] = 0;
        run_until_done(30, "lock");
        n_cmp++;
        if (out_ids.size() != exp.size()) begin
            n_err++;
            $display("FAIL lock_count got %0d want %0d", out_ids.size(), exp.size());
        end else begin
            for (int k = 0; k < exp.size(); k++) begin
                n_cmp++;
                if (out_ids[k] != exp[k]) begin
                    n_err++;
                    $display("FAIL lock_order[%0d] got %0d want %0d", k, out_ids[k], exp[k]);
                end
            end
        end
    endtask

    task automatic test_back_pressure();
        int exp[$];
        int c = 0;
        beat_t held;
        exp = '{0, 0, 0, 1};
        clear_log();
        len[0] = 3; left[0] = 1; bidx[0] = 0;
        len[1] = 1; left[1] = 1; bidx[1] = 0;
        while (bidx[0] < 1 && c < 10) begin step(); c++; end
        mg = 1'b0;
        held = out_beat();
        for (int s = 0; s < 5; s++) begin
            step();
            n_cmp++;
            if (cl_mem_gnt !== '0 || out_beat() !== held || mem_req !== 1'b1) begin
                n_err++;
                $display("FAIL bp_stall%0d got gnt=%b req=%b beat=%h want gnt=0 req=1 beat=%h", s, cl_mem_gnt, mem_req, out_beat(), held);
            end
        end
        mg = 1'b1;
        run_until_done(30, "bp");
        n_cmp++;
        if (out_ids.size() != exp.size()) begin
            n_err++;
            $display("FAIL bp_count got %0d want %0d", out_ids.size(), exp.size());
        end else begin
            for (int k = 0; k < exp.size(); k++) begin
                n_cmp++;
                if (out_ids[k] != exp[k]) begin
                    n_err++;
                    $display("FAIL bp_order[%0d] got %0d want %0d", k, out_ids[k], exp[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int c = 0;
        len[1] = 4; left[1] = 1; bidx[1] = 0;
        while (bidx[1] < 2 && c < 20) begin step(); c++; end
        apply_reset();
        left[1] = 0; bidx[1] = 0;
        n_cmp++;
        if (mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_mem_req got %b want 0", mem_req);
        end
        clear_log();
        len[3] = 1; left[3] = 1; bidx[3] = 0;
        drive();
        #1;
        n_cmp++;
        if (cl_mem_gnt !== 4'b1000) begin
            n_err++;
            $display("FAIL midrst_grant3 got %b want 1000", cl_mem_gnt);
        end
        run_until_done(20, "midrst");
        n_cmp++;
        if (out_ids.size() != 1 || out_ids[0] != 3) begin
            n_err++;
            $display("FAIL midrst_beat got %0d beats want 1 beat from client 3", out_ids.size());
        end
    endtask

    task automatic test_owner_drop();
        int exp[$];
        int c = 0;
        exp = '{2, 2, 2, 0};
        clear_log();
        len[2] = 3; left[2] = 1; bidx[2] = 0;
        while (bidx[2] < 1 && c < 10) begin step(); c++; end
        hold[2] = 1'b1;
        len[0] = 1; left[0] = 1; bidx[0] = 0;
        for (int s = 0; s < 4; s++) begin
            step();
            n_cmp++;
            if (cl_mem_gnt !== '0) begin
                n_err++;
                $display("FAIL drop_nogrant%0d got %b want 0000", s, cl_mem_gnt);
            end
        end
        hold[2] = 1'b0;
        run_until_done(30, "drop");
        n_cmp++;
        if (out_ids.size() != exp.size()) begin
            n_err++;
            $display("FAIL drop_count got %0d want %0d", out_ids.size(), exp.size());
        end else begin
            for (int k = 0; k < exp.size(); k++) begin
                n_cmp++;
                if (out_ids[k] != exp[k]) begin
                    n_err++;
                    $display("FAIL drop_order[%0d] got %0d want %0d", k, out_ids[k], exp[k]);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        mg = 1'b0;
        lat_pend = 1'b0;
        prev_stall = 1'b0;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_burst_lock();
        test_back_pressure();
        test_reset_mid_burst();
        test_owner_drop();
        n_cmp++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover got %0d want 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
